// File: rtl/bill_supply_ctrl.sv
// Metered supply billing controller: accrues usage per period, issues a bill, cuts the relay
// when the grace window lapses unpaid. Optional late fee on disconnection: BILL_SUPPLY_CTRL_LATE_FEE_EN.
//
// state   | meaning
// ACCUM   | counting usage over the billing period, nothing owed
// BILLED  | bill outstanding, supply on, grace window running
// DISCONN | grace lapsed unpaid, supply cut until fully settled
module bill_supply_ctrl #(
  parameter int RATE        = 2,
  parameter int BILL_PERIOD = 1000,
  parameter int GRACE       = 500,
  parameter int LATE_FEE    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       unit_pulse,
  input  logic       pay_valid,
  input  logic [7:0] amount_paid,
  output logic [7:0] expected_amount,
  output logic       bill_valid,
  output logic       supply_on,
  output logic       overdue,
  output logic       paid_ok,
  output logic       pay_reject
);

  localparam int PW = (BILL_PERIOD > 1) ? $clog2(BILL_PERIOD) : 1;
  localparam int GW = (GRACE > 1) ? $clog2(GRACE) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(BILL_PERIOD - 1);
  localparam logic [GW-1:0] GRACE_LAST  = GW'(GRACE - 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    BILLED  = 2'd1,
    DISCONN = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [GW-1:0] grace_cnt;
  logic [7:0]    usage;
  logic [7:0]    outstanding;

  logic [7:0]  usage_inc;
  logic [31:0] bill_full;
  logic [7:0]  bill_amt;
  logic [7:0]  pay_applied;
  logic [7:0]  remain;
  logic [7:0]  disc_amt;

`ifdef BILL_SUPPLY_CTRL_LATE_FEE_EN
  logic [31:0] fee_sum;
`else
  logic unused_late_fee;
  assign unused_late_fee = (LATE_FEE != 0);
`endif

  // Wide product so usage*RATE saturates cleanly instead of wrapping.
  always_comb begin
    usage_inc   = (usage == 8'hFF) ? usage : usage + 8'd1;
    bill_full   = 32'(usage) * 32'(RATE);
    bill_amt    = (bill_full > 32'd255) ? 8'hFF : bill_full[7:0];
    pay_applied = 8'd0;
    if (pay_valid)
      pay_applied = (amount_paid < outstanding) ? amount_paid : outstanding;
    remain      = outstanding - pay_applied;
`ifdef BILL_SUPPLY_CTRL_LATE_FEE_EN
    fee_sum  = 32'(remain) + 32'(LATE_FEE);
    disc_amt = (fee_sum > 32'd255) ? 8'hFF : fee_sum[7:0];
`else
    disc_amt = remain;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ACCUM;
      period_cnt      <= '0;
      grace_cnt       <= '0;
      usage           <= 8'd0;
      outstanding     <= 8'd0;
      expected_amount <= 8'd0;
      bill_valid      <= 1'b0;
      supply_on       <= 1'b1;
      overdue         <= 1'b0;
      paid_ok         <= 1'b0;
      pay_reject      <= 1'b0;
    end else begin
      paid_ok    <= 1'b0;
      pay_reject <= 1'b0;
      case (state)
        ACCUM: begin
          if (pay_valid)
            pay_reject <= 1'b1;
          if (period_cnt == PERIOD_LAST) begin
            // The pulse on the closing cycle belongs to the next period.
            period_cnt <= '0;
            usage      <= unit_pulse ? 8'd1 : 8'd0;
            grace_cnt  <= '0;
            if (bill_amt != 8'd0) begin
              state           <= BILLED;
              outstanding     <= bill_amt;
              expected_amount <= bill_amt;
              bill_valid      <= 1'b1;
            end
          end else begin
            period_cnt <= period_cnt + 1'b1;
            if (unit_pulse)
              usage <= usage_inc;
          end
        end

        BILLED: begin
          if (unit_pulse)
            usage <= usage_inc;
          grace_cnt <= grace_cnt + 1'b1;
          // A settling payment beats grace expiry in the same cycle.
          if (pay_valid && remain == 8'd0) begin
            state           <= ACCUM;
            outstanding     <= 8'd0;
            expected_amount <= 8'd0;
            bill_valid      <= 1'b0;
            supply_on       <= 1'b1;
            overdue         <= 1'b0;
            period_cnt      <= '0;
            paid_ok         <= 1'b1;
          end else if (grace_cnt == GRACE_LAST) begin
            state           <= DISCONN;
            supply_on       <= 1'b0;
            overdue         <= 1'b1;
            outstanding     <= disc_amt;
            expected_amount <= disc_amt;
          end else begin
            outstanding     <= remain;
            expected_amount <= remain;
          end
        end

        DISCONN: begin
          if (pay_valid) begin
            if (remain == 8'd0) begin
              state           <= ACCUM;
              outstanding     <= 8'd0;
              expected_amount <= 8'd0;
              bill_valid      <= 1'b0;
              supply_on       <= 1'b1;
              overdue         <= 1'b0;
              period_cnt      <= '0;
              paid_ok         <= 1'b1;
            end else begin
              outstanding     <= remain;
              expected_amount <= remain;
            end
          end
        end

        default: state <= ACCUM;
      endcase
    end
  end

endmodule
